// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the iterative multiply/divide unit.
// Op encodings match the instruction decoder's 2-bit mdu op field.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_sign.sv
// mdu_sign: conditional two's-complement negate.
// Used both to take operand magnitudes and to sign-fix results.
module mdu_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? ('0 - x_i) : x_i;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO.
// Magnitudes are iterated unsigned; signs are fixed up in FIX.
import mdu_pkg::*;

module mdu_iter #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q;
  op_e                op_q;
  logic               busy_q, done_q;
  logic               sa_q, sb_q, dz_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, m_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               sa_in, sb_in, div_in, div_q;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic [WIDTH:0]     shl, sum;
  logic               ge;
  logic [WIDTH-1:0]   rem_n;

  assign sa_in  = op[0] & a[WIDTH-1];
  assign sb_in  = op[0] & b[WIDTH-1];
  assign div_in = op[1];
  assign div_q  = (op_q == OP_DIVU) || (op_q == OP_DIV);

  mdu_sign #(.W(WIDTH)) u_abs_a (
    .x_i(a), .neg_i(sa_in), .y_o(abs_a)
  );

  mdu_sign #(.W(WIDTH)) u_abs_b (
    .x_i(b), .neg_i(sb_in), .y_o(abs_b)
  );

  mdu_sign #(.W(2*WIDTH)) u_fix_p (
    .x_i(acc_q), .neg_i(sa_q ^ sb_q), .y_o(prod_fix)
  );

  mdu_sign #(.W(WIDTH)) u_fix_q (
    .x_i(acc_q[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .y_o(quo_fix)
  );

  mdu_sign #(.W(WIDTH)) u_fix_r (
    .x_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .y_o(rem_fix)
  );

  // one radix-2 step: shift-add (multiply) or restoring shift-subtract (divide)
  always_comb begin
    acc_d = acc_q;
    shl   = '0;
    sum   = '0;
    ge    = 1'b0;
    rem_n = '0;
    if (div_q) begin
      shl   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      ge    = shl >= {1'b0, m_q};
      rem_n = ge ? (shl[WIDTH-1:0] - m_q) : shl[WIDTH-1:0];
      acc_d = {rem_n, acc_q[WIDTH-2:0], ge};
    end else begin
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + {1'b0, (acc_q[0] ? m_q : '0)};
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // control FSM, iteration counter, work registers and HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_MULTU;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (we_hi) hi_q <= wd;
          if (we_lo) lo_q <= wd;
          if (start) begin
            op_q    <= op_e'(op);
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            dz_q    <= (b == '0);
            cnt_q   <= '0;
            m_q     <= div_in ? abs_b : abs_a;
            acc_q   <= {{WIDTH{1'b0}}, (div_in ? abs_a : abs_b)};
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          if (div_q) begin
            // a zero divisor leaves |a| as remainder, so rem_fix is raw a
            lo_q <= dz_q ? '1 : quo_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized bench for mdu_iter.
// Reference results come from 64-bit integer arithmetic.
module tb_mdu_iter;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic         clk, rst, start, we_hi, we_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] model(
    input logic [1:0] o, input logic [31:0] x, input logic [31:0] y
  );
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: res = {32'b0, x} * {32'b0, y};
      2'b01: res = sx * sy;
      2'b10: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic do_op(
    input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
    output int bc, output int dc, output logic [31:0] h, output logic [31:0] l
  );
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    bc = 0; dc = 0; h = 'x; l = 'x;
    for (int i = 0; i < 60; i++) begin
      if (busy) bc++;
      if (done) begin dc++; h = hi; l = lo; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_vec++; if (hi !== '0) begin n_err++; $display("FAIL rst_hi got %h want 0", hi); end
    n_vec++; if (lo !== '0) begin n_err++; $display("FAIL rst_lo got %h want 0", lo); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ops(input bit dv, input int n);
    logic [1:0] o; logic [31:0] x, y, h, l; logic [63:0] e;
    int bc, dc;
    for (int i = 0; i < n; i++) begin
      o = dv ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) y = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      if (!dv && i == 0) begin o = 2'b00; x = 2; y = 4; end
      if (!dv && i == 1) begin o = 2'b01; x = 32'hFFFF_FFFD; y = 5; end
      if (dv && i == 0) begin o = 2'b11; x = 32'hFFFF_FFF9; y = 2; end
      do_op(o, x, y, bc, dc, h, l);
      e = model(o, x, y);
      n_vec++;
      if ({h, l} !== e) begin
        n_err++;
        $display("FAIL op%0d a=%h b=%h got hi=%h lo=%h want %h", o, x, y, h, l, e);
      end
      n_vec++; if (bc !== LAT) begin n_err++; $display("FAIL busy_len op%0d got %0d want %0d", o, bc, LAT); end
      n_vec++; if (dc !== 1) begin n_err++; $display("FAIL done_cnt op%0d got %0d want 1", o, dc); end
    end
  endtask

  task automatic test_boundary();
    logic [1:0] os [4]; logic [31:0] xs [4]; logic [31:0] ys [4];
    logic [31:0] h, l; logic [63:0] e; int bc, dc;
    os[0] = 2'b10; xs[0] = 7;            ys[0] = 0;
    os[1] = 2'b11; xs[1] = 32'h8000_0000; ys[1] = 32'hFFFF_FFFF;
    os[2] = 2'b11; xs[2] = 32'hFFFF_FF00; ys[2] = 0;
    os[3] = 2'b01; xs[3] = 32'h8000_0000; ys[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      do_op(os[i], xs[i], ys[i], bc, dc, h, l);
      e = model(os[i], xs[i], ys[i]);
      n_vec++;
      if ({h, l} !== e) begin
        n_err++;
        $display("FAIL bound%0d got hi=%h lo=%h want %h", i, h, l, e);
      end
      n_vec++; if (bc !== LAT) begin n_err++; $display("FAIL bound%0d_lat got %0d want %0d", i, bc, LAT); end
      n_vec++; if (dc !== 1) begin n_err++; $display("FAIL bound%0d_done got %0d want 1", i, dc); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, h, l; logic [63:0] e; int bc, dc;
    x = $urandom; y = $urandom;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    bc = 0; dc = 0; h = 'x; l = 'x;
    for (int i = 0; i < 60; i++) begin
      if (busy) bc++;
      if (done) begin dc++; h = hi; l = lo; end
      start = (i == 5);
      if (i == 5) begin op = 2'b11; a = ~x; b = 32'd3; end
      @(negedge clk);
    end
    start = 1'b0;
    e = model(2'b00, x, y);
    n_vec++; if ({h, l} !== e) begin n_err++; $display("FAIL b2b got %h%h want %h", h, l, e); end
    n_vec++; if (bc !== LAT) begin n_err++; $display("FAIL b2b_lat got %0d want %0d", bc, LAT); end
    n_vec++; if (dc !== 1) begin n_err++; $display("FAIL b2b_done got %0d want 1", dc); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] x, y, h, l; logic [63:0] e; int dc;
    @(negedge clk);
    we_hi = 1'b1; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    we_hi = 1'b0;
    n_vec++; if (hi !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mthi got %h want deadbeef", hi); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mthi_done got %b want 0", done); end
    we_lo = 1'b1; wd = 32'h0BAD_F00D;
    @(negedge clk);
    we_lo = 1'b0;
    n_vec++; if (lo !== 32'h0BAD_F00D) begin n_err++; $display("FAIL mtlo got %h want 0badf00d", lo); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mtlo_done got %b want 0", done); end
    x = $urandom; y = $urandom;
    start = 1'b1; op = 2'b01; a = x; b = y;
    we_hi = 1'b1; wd = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0;
    n_vec++; if (hi !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mthi_start got %h want cafef00d", hi); end
    dc = 0; h = 'x; l = 'x;
    for (int i = 0; i < 60; i++) begin
      if (i == 11 && lo !== 32'h0BAD_F00D) begin
        n_err++; $display("FAIL mtlo_busy got %h want 0badf00d", lo);
      end
      if (i == 11) n_vec++;
      if (done) begin dc++; h = hi; l = lo; end
      we_lo = (i == 10);
      wd = 32'h5555_5555;
      @(negedge clk);
    end
    we_lo = 1'b0;
    e = model(2'b01, x, y);
    n_vec++; if ({h, l} !== e) begin n_err++; $display("FAIL mtlo_res got %h%h want %h", h, l, e); end
    n_vec++; if (dc !== 1) begin n_err++; $display("FAIL mtlo_res_done got %0d want 1", dc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] h, l; int bc, dc, nb;
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'h1234_5678; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_vec++; if (hi !== '0) begin n_err++; $display("FAIL mid_rst_hi got %h want 0", hi); end
    n_vec++; if (lo !== '0) begin n_err++; $display("FAIL mid_rst_lo got %h want 0", lo); end
    @(negedge clk);
    rst = 1'b1;
    dc = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      if (busy) nb++;
      @(negedge clk);
    end
    n_vec++; if (dc !== 0) begin n_err++; $display("FAIL mid_rst_done got %0d want 0", dc); end
    n_vec++; if (nb !== 0) begin n_err++; $display("FAIL mid_rst_busy_after got %0d want 0", nb); end
    do_op(2'b00, 32'd3, 32'd3, bc, dc, h, l);
    n_vec++; if ({h, l} !== 64'd9) begin n_err++; $display("FAIL post_rst got %h%h want 9", h, l); end
    n_vec++; if (bc !== LAT) begin n_err++; $display("FAIL post_rst_lat got %0d want %0d", bc, LAT); end
  endtask

  initial begin
    start = 1'b0; op = 2'b00; a = '0; b = '0;
    we_hi = 1'b0; we_lo = 1'b0; wd = '0;
    test_reset();
    test_ops(1'b0, 16);
    test_ops(1'b1, 20);
    test_boundary();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative multiply/divide unit with its own architectural HI/LO registers. It generalises the single-cycle MULTU + HILO path to a parametrised WIDTH and adds MULT (signed), DIVU and DIV. It also provides MTHI/MTLO writes and a start/busy/done handshake, so the datapath can stall on busy. It sits beside the ALU in the datapath; MFHI/MFLO read hi/lo directly.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  launch operation; sampled only when busy=0
op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  in  WIDTH  operand rs (multiplicand / dividend)
b  in  WIDTH  operand rt (multiplier / divisor)
we_hi  in  1  MTHI write strobe
we_lo  in  1  MTLO write strobe
wd  in  WIDTH  MTHI/MTLO write data
busy  out  1  operation in flight
done  out  1  one-cycle pulse: HI/LO just updated by an operation
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and work registers cleared. Reset during CALC or FIX aborts the operation; no done pulse follows.
- States:
  - IDLE: start=1 latches |a|, |b|, sign_a, sign_b, op and div-by-zero flag (b==0); counter=0; next state CALC.
  - CALC: one radix-2 step per cycle for exactly WIDTH cycles. Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring shift-subtract giving quotient and remainder. After WIDTH steps, next state FIX.
  - FIX: one cycle. Applies sign correction, writes hi/lo, sets done=1 for the following cycle, then returns to IDLE.
- busy = (state != IDLE), driven from a register.
- Latency: start sampled at edge E0; hi/lo updated and done asserted at edge E(WIDTH+1); busy is high from E0 to E(WIDTH+1). WIDTH=32 gives 33 busy cycles.
- start while busy=1: ignored; operands are not re-latched.
- Results:
  - MULTU/MULT: {hi,lo} = full 2*WIDTH product. MULT negates the product when sign_a^sign_b.
  - DIVU/DIV: lo = quotient, hi = remainder. DIV negates the quotient when sign_a^sign_b, and gives the remainder the sign of a (truncation toward zero).
  - Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0. This falls out of wrap arithmetic and needs no special case.
  - Divide by zero (DIVU or DIV): lo = all ones, hi = a (raw, unmodified). Forced in FIX; full latency is still taken.
- Signed magnitude: the absolute value of the most-negative operand is held in WIDTH bits as unsigned; no overflow results.
- MTHI/MTLO: we_hi/we_lo write wd on the next edge, in IDLE only. While busy they are dropped; the controller must stall, so no queueing is done.
- we_hi/we_lo together with start in IDLE: the write applies; the operation begins and later overwrites both registers.
- done is never asserted by MTHI/MTLO.

Decomposition:
- Package mdu_pkg: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state enum (IDLE, CALC, FIX), WIDTH default constant.
- One combinational sub-module, mdu_sign: abs and conditional negate, parametrised by WIDTH. It is instantiated for operand magnitude and for result fix-up (2*WIDTH product, quotient, remainder).
- Control FSM, counter, accumulators and HI/LO stay in mdu_iter.

Test Plan:
1. MULTU a=2, b=4 -> busy for 33 cycles; at done: hi=0x00000000, lo=0x00000008.
2. MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. Boundary cases:
   - DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007, latency 33.
   - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Second start 5 cycles into a MULTU (different operands) -> ignored; the result matches the first operands only, with a single done pulse.
5. MTHI wd=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, done stays 0. MTLO issued during busy -> lo unchanged until the operation result lands.
6. rst driven low 10 cycles into DIVU, asynchronously mid-cycle -> busy=0, hi=lo=0 immediately. After release, no done pulse; a fresh MULTU 3*3 then gives lo=9.
